pixel_burst_engine: RTL and testbench
=====================================

PIXEL_BURST_ENGINE -- requirements
Module: pixel_burst_engine

Interface
REQ-001 ADDR_W, 16, SRAM address width.
REQ-002 PIX_W, 24, SRAM word width; packed RGB, R=[23:16], G=[15:8], B=[7:0].
REQ-003 DEPTH, 20, pixel buffer entries, 8 bits each.
REQ-004 RD_LAT, 2, cycles read_enable is held per pixel before r_data is sampled; legal range >=1.
REQ-005 clk  input  1  system clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  burst request; sampled only in IDLE.
REQ-008 mode  input  1  0 = read burst (SRAM -> buffer), 1 = write burst (buffer -> SRAM).
REQ-009 base_addr  input  ADDR_W  SRAM address of pixel 0.
REQ-010 num_pix  input  $clog2(DEPTH+1)  pixels in burst.
REQ-011 data_in  input  DEPTH x 8  write-burst source pixels.
REQ-012 data_out  output  DEPTH x 8  read-burst result buffer.
REQ-013 busy  output  1  burst in progress.
REQ-014 done  output  1  one-cycle end-of-burst pulse.
REQ-015 address  output  ADDR_W  SRAM address.
REQ-016 read_enable / write_enable  output  1 each  SRAM strobes; never both high.
REQ-017 w_data  output  PIX_W  SRAM write word.
REQ-018 r_data  input  PIX_W  SRAM read word.

Function
REQ-019 FSM states: IDLE, RD_ACCESS, WR_DRIVE, WR_RELEASE, FINISH.
REQ-020 IDLE with start=1: latch mode, base_addr, count=min(num_pix,DEPTH), snapshot of data_in; index=0; next state RD_ACCESS or WR_DRIVE per mode.
REQ-021 IDLE with start=1 and num_pix=0: next state FINISH, no SRAM strobe.
REQ-022 Pixel address = base_addr+index, modulo 2^ADDR_W (wraps 0xFFFF -> 0x0000).
REQ-023 RD_ACCESS: read_enable=1 and address held for RD_LAT consecutive cycles per pixel; r_data sampled at the clock edge ending the RD_LAT-th cycle.
REQ-024 Sampled pixel stored as luma (R+2G+B)>>2, computed at 10 bits, truncated to 8, into data_out[index].
REQ-025 Read burst of N pixels: read_enable high N*RD_LAT contiguous cycles, then FINISH.
REQ-026 WR_DRIVE (1 cycle): write_enable=1, address per REQ-022, w_data={p,p,p}, p = snapshot[index].
REQ-027 WR_RELEASE (1 cycle): write_enable=0, address and w_data held; index++; then WR_DRIVE, or FINISH after last pixel.
REQ-028 busy=1 in RD_ACCESS, WR_DRIVE, WR_RELEASE; 0 in IDLE and FINISH.
REQ-029 FINISH: done=1 for exactly one cycle, then IDLE; start in FINISH ignored.
REQ-030 start while busy ignored; latched parameters unaffected.
REQ-031 data_out entries at index>=count unchanged; data_out holds between bursts.
REQ-032 IDLE/FINISH: address=0, w_data=0, both strobes 0.
REQ-033 data_in changes during a burst do not affect written data.

Reset
REQ-034 rst=1 forces IDLE, all outputs 0, data_out all 0, asynchronously.
REQ-035 Reset mid-burst: strobes drop immediately; no done pulse; no partial data_out update on that edge.

Structure
REQ-036 Shared package pixel_pkg holds state enum, mode enum (MODE_READ, MODE_WRITE), RGB field offsets.
REQ-037 Combinational sub-module pixel_luma (PIX_W in, 8-bit out) implements REQ-024.

Verification
REQ-038 Read: SRAM[0x0010..0x0013]=0xFF0000,0x00FF00,0x0000FF,0xFFFFFF, start mode=0 num_pix=4 -> data_out[0..3]=0x3F,0x7F,0x3F,0xFF; done 8 cycles after busy rises (RD_LAT=2).
REQ-039 Write: data_in[0..2]=0x11,0x22,0x33, base=0x0100, num_pix=3 -> SRAM[0x0100..0x0102]=0x111111,0x222222,0x333333; write_enable high 3 single cycles separated by low cycles.
REQ-040 Wrap: base=0xFFFE, num_pix=4, read -> addresses 0xFFFE,0xFFFF,0x0000,0x0001 in order.
REQ-041 Boundaries: num_pix=0 -> done next cycle, no strobe; num_pix=25 -> exactly 20 pixels transferred; start pulsed mid-burst -> ignored.
REQ-042 Reset mid-burst after pixel 2 of 4 -> strobes 0 same cycle, data_out all 0, no done; fresh burst afterwards completes correctly.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared types for the pixel burst engine: FSM states, burst modes
// and RGB field offsets within an SRAM pixel word.
package pixel_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ACCESS,
    S_WR_DRIVE,
    S_WR_RELEASE,
    S_FINISH
  } state_t;

  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } mode_t;

  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

endpackage

// File: rtl/pixel_luma.sv
// Combinational RGB -> 8-bit luma: (R + 2G + B) >> 2 at 10 bits.
// Ports: pix (packed RGB word) in, luma (8 bits) out.
module pixel_luma
  import pixel_pkg::*;
#(
  parameter int PIX_W = 24
) (
  input  logic [PIX_W-1:0] pix,
  output logic [7:0]       luma
);

  logic [9:0] sum;

  always_comb begin
    sum = 10'(pix[R_LSB +: 8])
        + {1'b0, pix[G_LSB +: 8], 1'b0}
        + 10'(pix[B_LSB +: 8]);
    luma = 8'(sum >> 2);
  end

endmodule

// File: rtl/pixel_burst_engine.sv
// Burst mover between an SRAM and an 8-bit pixel buffer.
// Ports: start/mode/base_addr/num_pix request a burst; data_in is the
// write source, data_out the read result; busy/done report progress;
// address/read_enable/write_enable/w_data/r_data form the SRAM side.
module pixel_burst_engine
  import pixel_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 24,
  parameter int DEPTH  = 20,
  parameter int RD_LAT = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      num_pix,
  input  logic [DEPTH-1:0][7:0] data_in,
  output logic [DEPTH-1:0][7:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     address,
  output logic                  read_enable,
  output logic                  write_enable,
  output logic [PIX_W-1:0]      w_data,
  input  logic [PIX_W-1:0]      r_data
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       idx_q, idx_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic [DEPTH-1:0][7:0]  snap_q, snap_d;
  logic [DEPTH-1:0][7:0]  dout_q, dout_d;

  logic [7:0]             luma;
  logic [7:0]             pix_sel;
  logic [CNT_W-1:0]       num_clamped;
  logic                   last_pix;
  logic                   lat_end;
  logic [ADDR_W-1:0]      pix_addr;

  pixel_luma #(.PIX_W(PIX_W)) u_luma (
    .pix  (r_data),
    .luma (luma)
  );

  assign num_clamped = (num_pix > CNT_W'(DEPTH)) ? CNT_W'(DEPTH)
                                                 : num_pix;
  assign last_pix = (idx_q == count_q - CNT_W'(1));
  assign lat_end  = (lat_q == LAT_W'(RD_LAT - 1));
  assign pix_sel  = snap_q[idx_q];
  assign pix_addr = base_q + ADDR_W'(idx_q);
  assign data_out = dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      lat_q   <= '0;
      snap_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      snap_q  <= snap_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    snap_d  = snap_q;
    dout_d  = dout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          count_d = num_clamped;
          snap_d  = data_in;
          idx_d   = '0;
          lat_d   = '0;
          if (num_pix == '0)
            state_d = S_FINISH;
          else if (mode_t'(mode) == MODE_WRITE)
            state_d = S_WR_DRIVE;
          else
            state_d = S_RD_ACCESS;
        end
      end
      S_RD_ACCESS: begin
        if (lat_end) begin
          // r_data is captured on the edge closing the last hold cycle
          dout_d[idx_q] = luma;
          lat_d = '0;
          if (last_pix) state_d = S_FINISH;
          else          idx_d = idx_q + CNT_W'(1);
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_WR_DRIVE: begin
        state_d = S_WR_RELEASE;
      end
      S_WR_RELEASE: begin
        if (last_pix) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + CNT_W'(1);
          state_d = S_WR_DRIVE;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode from state only, so reset drops them at once.
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    address      = '0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    w_data       = '0;
    unique case (state_q)
      S_RD_ACCESS: begin
        busy        = 1'b1;
        read_enable = 1'b1;
        address     = pix_addr;
      end
      S_WR_DRIVE: begin
        busy         = 1'b1;
        write_enable = 1'b1;
        address      = pix_addr;
        w_data       = PIX_W'({3{pix_sel}});
      end
      S_WR_RELEASE: begin
        busy    = 1'b1;
        address = pix_addr;
        w_data  = PIX_W'({3{pix_sel}});
      end
      S_FINISH: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_pixel_burst_engine.sv
// Directed self-checking bench for pixel_burst_engine with a
// behavioural SRAM and a strobe/address monitor.
module tb_pixel_burst_engine;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              mode;
  logic [15:0]       base_addr;
  logic [4:0]        num_pix;
  logic [19:0][7:0]  data_in;
  logic [19:0][7:0]  data_out;
  logic              busy;
  logic              done;
  logic [15:0]       address;
  logic              read_enable;
  logic              write_enable;
  logic [23:0]       w_data;
  logic [23:0]       r_data;

  logic [23:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  int rd_cnt = 0, wr_cnt = 0, wr_pulses = 0;
  int both_err = 0, done_cnt = 0;
  logic prev_re = 1'b0, prev_we = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [15:0] addr_log [$];

  pixel_burst_engine dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode         (mode),
    .base_addr    (base_addr),
    .num_pix      (num_pix),
    .data_in      (data_in),
    .data_out     (data_out),
    .busy         (busy),
    .done         (done),
    .address      (address),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .w_data       (w_data),
    .r_data       (r_data)
  );

  always #5 clk = ~clk;

  assign r_data = mem[address];

  always @(posedge clk)
    if (write_enable) mem[address] <= w_data;

  always @(negedge clk) begin
    if (read_enable) begin
      rd_cnt++;
      if (!prev_re || address != prev_addr) addr_log.push_back(address);
    end
    if (write_enable) begin
      wr_cnt++;
      if (!prev_we) wr_pulses++;
    end
    if (read_enable && write_enable) both_err++;
    if (done) done_cnt++;
    prev_re   = read_enable;
    prev_we   = write_enable;
    prev_addr = address;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_burst(input logic md, input logic [15:0] b,
                           input logic [4:0] n, input bit disturb,
                           output int cyc);
    @(negedge clk);
    mode = md; base_addr = b; num_pix = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      if (disturb && cyc == 2) begin
        start = 1'b1; mode = ~md; base_addr = 16'h5555; num_pix = 5'd1;
        data_in[0] = 8'hEE; data_in[2] = 8'hEE;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_timeout", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int rd0, wr0, wp0, dn0, q0;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'h0010] = 24'hFF0000;
    mem[16'h0011] = 24'h00FF00;
    mem[16'h0012] = 24'h0000FF;
    mem[16'h0013] = 24'hFFFFFF;
    mem[16'hFFFE] = 24'h040404;
    mem[16'hFFFF] = 24'h080808;
    mem[16'h0000] = 24'h0C0C0C;
    mem[16'h0001] = 24'h101010;
    for (int i = 0; i < 25; i++) mem[16'h0200 + i] = {3{8'(i + 1)}};
    start = 0; mode = 0; base_addr = '0; num_pix = '0; data_in = '0;

    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(address), 0);
    chk("rst_strobes", 32'({read_enable, write_enable}), 0);
    chk("rst_dout", 32'(data_out == '0), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // read burst
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    run_burst(1'b0, 16'h0010, 5'd4, 1'b0, cyc);
    chk("rd_latency", 32'(cyc), 8);
    chk("rd_px0", 32'(data_out[0]), 32'h3F);
    chk("rd_px1", 32'(data_out[1]), 32'h7F);
    chk("rd_px2", 32'(data_out[2]), 32'h3F);
    chk("rd_px3", 32'(data_out[3]), 32'hFF);
    chk("rd_px4_keep", 32'(data_out[4]), 0);
    chk("rd_re_cycles", 32'(rd_cnt - rd0), 8);
    chk("rd_no_we", 32'(wr_cnt - wr0), 0);
    chk("rd_done_once", 32'(done_cnt - dn0), 1);
    chk("rd_idle_busy", 32'(busy), 0);

    // write burst with mid-burst start and data_in change
    data_in[0] = 8'h11; data_in[1] = 8'h22; data_in[2] = 8'h33;
    wr0 = wr_cnt; wp0 = wr_pulses; rd0 = rd_cnt;
    run_burst(1'b1, 16'h0100, 5'd3, 1'b1, cyc);
    chk("wr_latency", 32'(cyc), 6);
    chk("wr_m0", 32'(mem[16'h0100]), 32'h111111);
    chk("wr_m1", 32'(mem[16'h0101]), 32'h222222);
    chk("wr_m2", 32'(mem[16'h0102]), 32'h333333);
    chk("wr_no_extra", 32'(mem[16'h0103]), 0);
    chk("wr_ignored_start", 32'(mem[16'h5555]), 0);
    chk("wr_we_cycles", 32'(wr_cnt - wr0), 3);
    chk("wr_we_pulses", 32'(wr_pulses - wp0), 3);
    chk("wr_no_re", 32'(rd_cnt - rd0), 0);
    chk("wr_dout_hold", 32'(data_out[1]), 32'h7F);

    // address wrap
    q0 = addr_log.size();
    run_burst(1'b0, 16'hFFFE, 5'd4, 1'b0, cyc);
    chk("wrap_naddr", 32'(addr_log.size() - q0), 4);
    if (addr_log.size() >= q0 + 4) begin
      chk("wrap_a0", 32'(addr_log[q0]), 32'hFFFE);
      chk("wrap_a1", 32'(addr_log[q0 + 1]), 32'hFFFF);
      chk("wrap_a2", 32'(addr_log[q0 + 2]), 32'h0000);
      chk("wrap_a3", 32'(addr_log[q0 + 3]), 32'h0001);
    end
    chk("wrap_px2", 32'(data_out[2]), 32'h0C);

    // zero-length burst
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_burst(1'b0, 16'h0010, 5'd0, 1'b0, cyc);
    chk("zero_latency", 32'(cyc), 0);
    chk("zero_strobes", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 0);

    // oversize burst clamps to 20
    rd0 = rd_cnt; q0 = addr_log.size();
    run_burst(1'b0, 16'h0200, 5'd25, 1'b0, cyc);
    chk("clamp_latency", 32'(cyc), 40);
    chk("clamp_re_cycles", 32'(rd_cnt - rd0), 40);
    chk("clamp_naddr", 32'(addr_log.size() - q0), 20);
    chk("clamp_px0", 32'(data_out[0]), 32'h01);
    chk("clamp_px19", 32'(data_out[19]), 32'h14);

    // reset after two of four pixels
    @(negedge clk);
    mode = 1'b0; base_addr = 16'h0010; num_pix = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    dn0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_re", 32'(read_enable), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_addr", 32'(address), 0);
    chk("mid_rst_dout", 32'(data_out == '0), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_no_done", 32'(done_cnt - dn0), 0);
    run_burst(1'b0, 16'h0010, 5'd4, 1'b0, cyc);
    chk("fresh_latency", 32'(cyc), 8);
    chk("fresh_px1", 32'(data_out[1]), 32'h7F);
    chk("fresh_px3", 32'(data_out[3]), 32'hFF);
    chk("fresh_px4", 32'(data_out[4]), 0);

    chk("both_strobes", 32'(both_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
